sequence_game_engine: RTL and testbench

Parametrised memory-sequence ("play it back") game core. Plays the first cur_len notes of a loaded sequence as timed tones, then accepts keypad notes in forward or reverse order, echoing each key as a tone. It grows the sequence by one note per cleared round and tracks lives and score. Sits between the keypad debouncer/CPU write port and the piezo/LED drivers; successor to the fixed 8-note, reverse-only game module.

---
 rtl/sequence_game_engine.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_sequence_game_engine.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_game_engine.sv
// sequence_game_engine: memory-sequence ("play it back") game core.
// Plays the first cur_len notes of the loaded sequence as timed tones, then
// takes keypad notes in forward or reverse order and echoes each one. A cleared
// round grows the sequence by one note. A wrong key costs a life.
// Optional feature: define INPUT_TIMEOUT_EN so that TIMEOUT_TICKS ticks without
// a key in WAIT_KEY count as a wrong key.
module sequence_game_engine #(
  parameter int NOTE_W        = 3,
  parameter int MAX_LEN       = 8,
  parameter int START_LEN     = 3,
  parameter int TICK_DIV      = 500000,
  parameter int ON_TICKS      = 2,
  parameter int OFF_TICKS     = 2,
  parameter int LIVES         = 3,
  parameter int TIMEOUT_TICKS = 20
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      seq_wr,
  input  logic [MAX_LEN*NOTE_W-1:0] seq_data,
  input  logic                      start,
  input  logic                      reverse_mode,
  input  logic                      key_valid,
  input  logic [NOTE_W-1:0]         key_note,
  output logic                      key_ready,
  output logic [NOTE_W-1:0]         tone,
  output logic                      tone_en,
  output logic [4:0]                cur_len,
  output logic [2:0]                lives_left,
  output logic [7:0]                score,
  output logic                      miss,
  output logic                      round_win,
  output logic                      game_over,
  output logic                      game_won,
  output logic [2:0]                state_out
);

  localparam int IDX_W  = $clog2(MAX_LEN);
  localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TMAX_A = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TMAX   = (TMAX_A > TIMEOUT_TICKS) ? TMAX_A : TIMEOUT_TICKS;
  localparam int TC_W   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PLAY_ON  = 3'd1,
    S_PLAY_OFF = 3'd2,
    S_WAIT_KEY = 3'd3,
    S_ECHO     = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t state, next_state;

  logic [PRE_W-1:0]          presc;
  logic [TC_W-1:0]           tick_cnt;
  logic                      tick, on_done, off_done;

  logic                      loaded, loaded_n;
  logic [MAX_LEN*NOTE_W-1:0] notes, notes_n;
  logic                      rev, rev_n;
  logic [IDX_W-1:0]          idx, idx_n;
  logic [IDX_W-1:0]          ans, ans_n;
  logic                      replay, replay_n;
  logic [NOTE_W-1:0]         key_reg, key_reg_n;
  logic                      match_q, match_n;
  logic [4:0]                cur_len_n;
  logic [2:0]                lives_n;
  logic [7:0]                score_n;
  logic                      miss_n, round_win_n, game_over_n, game_won_n;
  logic                      tone_en_n, key_ready_n;
  logic [NOTE_W-1:0]         tone_n;
  logic                      lose_life;

  logic                      idle_like, load_ok, start_ok;
  logic                      last_ans, more_notes, final_life, at_max;

  logic [NOTE_W-1:0]         note_arr [MAX_LEN];

`ifdef INPUT_TIMEOUT_EN
  logic                      to_done;
  assign to_done = tick && (tick_cnt == TC_W'(TIMEOUT_TICKS - 1));
`endif

  // Unpack the loaded sequence so notes can be picked by index.
  always_comb begin
    for (int i = 0; i < MAX_LEN; i++) begin
      note_arr[i] = notes[i*NOTE_W +: NOTE_W];
    end
  end

  assign tick       = (presc == PRE_W'(TICK_DIV - 1));
  assign on_done    = tick && (tick_cnt == TC_W'(ON_TICKS - 1));
  assign off_done   = tick && (tick_cnt == TC_W'(OFF_TICKS - 1));
  assign idle_like  = (state == S_IDLE) || (state == S_DONE);
  assign load_ok    = seq_wr && idle_like;
  assign start_ok   = start && !seq_wr && loaded && idle_like;
  assign last_ans   = rev ? (ans == '0) : (5'(ans) == cur_len - 5'd1);
  assign more_notes = (5'(idx) < cur_len - 5'd1);
  assign final_life = (lives_left == 3'd1);
  assign at_max     = (cur_len == 5'(MAX_LEN));
  assign state_out  = state;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state decision; the replay flag forces a restart at note 0 after the gap.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_DONE: if (start_ok) next_state = S_PLAY_ON;
      S_PLAY_ON:      if (on_done) next_state = S_PLAY_OFF;
      S_PLAY_OFF: begin
        if (off_done) next_state = (replay || more_notes) ? S_PLAY_ON : S_WAIT_KEY;
      end
      S_WAIT_KEY: begin
        if (key_valid) next_state = S_ECHO;
`ifdef INPUT_TIMEOUT_EN
        else if (to_done) next_state = final_life ? S_DONE : S_PLAY_OFF;
`endif
      end
      S_ECHO: begin
        if (on_done) begin
          if (match_q) begin
            if (!last_ans)   next_state = S_WAIT_KEY;
            else if (at_max) next_state = S_DONE;
            else             next_state = S_PLAY_OFF;
          end else begin
            next_state = final_life ? S_DONE : S_PLAY_OFF;
          end
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Tick prescaler and per-state tick counter, both restarted on every state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc    <= '0;
      tick_cnt <= '0;
    end else if (next_state != state) begin
      presc    <= '0;
      tick_cnt <= '0;
    end else if (tick) begin
      presc    <= '0;
      tick_cnt <= tick_cnt + 1'b1;
    end else begin
      presc    <= presc + 1'b1;
    end
  end

  // Game bookkeeping: loading, start, play index, answer index, scoring and lives.
  always_comb begin
    loaded_n    = loaded;
    notes_n     = notes;
    rev_n       = rev;
    idx_n       = idx;
    ans_n       = ans;
    replay_n    = replay;
    key_reg_n   = key_reg;
    match_n     = match_q;
    cur_len_n   = cur_len;
    lives_n     = lives_left;
    score_n     = score;
    game_over_n = game_over;
    game_won_n  = game_won;
    miss_n      = 1'b0;
    round_win_n = 1'b0;
    lose_life   = 1'b0;

    if (load_ok) begin
      loaded_n = 1'b1;
      notes_n  = seq_data;
    end
    if (start_ok) begin
      cur_len_n   = 5'(START_LEN);
      lives_n     = 3'(LIVES);
      score_n     = '0;
      game_over_n = 1'b0;
      game_won_n  = 1'b0;
      rev_n       = reverse_mode;
      idx_n       = '0;
      replay_n    = 1'b0;
    end

    case (state)
      S_PLAY_OFF: begin
        if (off_done) begin
          if (replay)          replay_n = 1'b0;
          else if (more_notes) idx_n    = idx + 1'b1;
          else                 ans_n    = rev ? IDX_W'(cur_len - 5'd1) : '0;
        end
      end
      S_WAIT_KEY: begin
        if (key_valid) begin
          key_reg_n = key_note;
          match_n   = (key_note == note_arr[ans]);
        end
`ifdef INPUT_TIMEOUT_EN
        else if (to_done) begin
          lose_life = 1'b1;
        end
`endif
      end
      S_ECHO: begin
        if (on_done) begin
          if (match_q) begin
            score_n = (score == 8'hFF) ? score : score + 8'd1;
            if (!last_ans) begin
              ans_n = rev ? ans - 1'b1 : ans + 1'b1;
            end else begin
              round_win_n = 1'b1;
              if (at_max) begin
                game_won_n = 1'b1;
              end else begin
                cur_len_n = cur_len + 5'd1;
                idx_n     = '0;
                replay_n  = 1'b1;
              end
            end
          end else begin
            lose_life = 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (lose_life) begin
      miss_n  = 1'b1;
      lives_n = lives_left - 3'd1;
      if (final_life) begin
        game_over_n = 1'b1;
      end else begin
        idx_n    = '0;
        replay_n = 1'b1;
      end
    end
  end

  // Tone and handshake outputs derived from the state being entered.
  always_comb begin
    tone_en_n   = (next_state == S_PLAY_ON) || (next_state == S_ECHO);
    key_ready_n = (next_state == S_WAIT_KEY);
    tone_n      = '0;
    if (next_state == S_PLAY_ON)   tone_n = note_arr[idx_n];
    else if (next_state == S_ECHO) tone_n = key_reg_n;
  end

  // Register all datapath state and outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      loaded     <= 1'b0;
      notes      <= '0;
      rev        <= 1'b0;
      idx        <= '0;
      ans        <= '0;
      replay     <= 1'b0;
      key_reg    <= '0;
      match_q    <= 1'b0;
      cur_len    <= '0;
      lives_left <= '0;
      score      <= '0;
      miss       <= 1'b0;
      round_win  <= 1'b0;
      game_over  <= 1'b0;
      game_won   <= 1'b0;
      tone_en    <= 1'b0;
      key_ready  <= 1'b0;
      tone       <= '0;
    end else begin
      loaded     <= loaded_n;
      notes      <= notes_n;
      rev        <= rev_n;
      idx        <= idx_n;
      ans        <= ans_n;
      replay     <= replay_n;
      key_reg    <= key_reg_n;
      match_q    <= match_n;
      cur_len    <= cur_len_n;
      lives_left <= lives_n;
      score      <= score_n;
      miss       <= miss_n;
      round_win  <= round_win_n;
      game_over  <= game_over_n;
      game_won   <= game_won_n;
      tone_en    <= tone_en_n;
      key_ready  <= key_ready_n;
      tone       <= tone_n;
    end
  end

endmodule

// File: tb/tb_sequence_game_engine.sv
// tb_sequence_game_engine: randomized scoreboard bench for sequence_game_engine.
// The stimulus thread plays whole games from a simple game model and queues the
// tones, misses and round wins it expects; a monitor compares what the DUT emits.
module tb_sequence_game_engine;

  localparam int NOTE_W    = 3;
  localparam int MAX_LEN   = 4;
  localparam int START_LEN = 3;
  localparam int TICK_DIV  = 4;
  localparam int ON_TICKS  = 2;
  localparam int OFF_TICKS = 2;
  localparam int LIVES     = 2;
  localparam int TONE_LEN  = ON_TICKS * TICK_DIV;
  localparam int GAP_LEN   = OFF_TICKS * TICK_DIV;

  localparam int EV_TONE = 0;
  localparam int EV_MISS = 1;
  localparam int EV_WIN  = 2;

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic                      seq_wr = 1'b0;
  logic [MAX_LEN*NOTE_W-1:0] seq_data = '0;
  logic                      start = 1'b0;
  logic                      reverse_mode = 1'b0;
  logic                      key_valid = 1'b0;
  logic [NOTE_W-1:0]         key_note = '0;
  logic                      key_ready;
  logic [NOTE_W-1:0]         tone;
  logic                      tone_en;
  logic [4:0]                cur_len;
  logic [2:0]                lives_left;
  logic [7:0]                score;
  logic                      miss;
  logic                      round_win;
  logic                      game_over;
  logic                      game_won;
  logic [2:0]                state_out;

  sequence_game_engine #(
    .NOTE_W(NOTE_W), .MAX_LEN(MAX_LEN), .START_LEN(START_LEN), .TICK_DIV(TICK_DIV),
    .ON_TICKS(ON_TICKS), .OFF_TICKS(OFF_TICKS), .LIVES(LIVES), .TIMEOUT_TICKS(20)
  ) dut (
    .clk(clk), .reset(reset), .seq_wr(seq_wr), .seq_data(seq_data), .start(start),
    .reverse_mode(reverse_mode), .key_valid(key_valid), .key_note(key_note),
    .key_ready(key_ready), .tone(tone), .tone_en(tone_en), .cur_len(cur_len),
    .lives_left(lives_left), .score(score), .miss(miss), .round_win(round_win),
    .game_over(game_over), .game_won(game_won), .state_out(state_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int note;
    int gap;
  } ev_t;

  ev_t sb_q[$];
  int  n_checks = 0;
  int  n_fail = 0;

  // Game model
  int m_notes [MAX_LEN];
  int m_len, m_lives, m_score;
  bit m_rev, m_over, m_won;

  // Monitor bookkeeping
  int in_tone = 0;
  int tone_len = 0;
  int tone_val = 0;
  int tone_glitch = 0;
  int gap_seen = 0;
  int low_run = 0;

  task automatic check_output(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic score_event(input int kind, input int note, input int len, input int gap);
    ev_t e;
    bit  ok;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("[TB] FAIL sb_unexpected: got kind=%0d note=%0d len=%0d gap=%0d, expected no event",
               kind, note, len, gap);
      return;
    end
    e  = sb_q.pop_front();
    ok = (kind == e.kind);
    if (ok && kind == EV_TONE)
      ok = (note == e.note) && (len == TONE_LEN) && (e.gap < 0 || gap == e.gap);
    if (!ok) begin
      n_fail++;
      $display("[TB] FAIL sb_event: got kind=%0d note=%0d len=%0d gap=%0d, expected kind=%0d note=%0d len=%0d gap=%0d",
               kind, note, len, gap, e.kind, e.note, TONE_LEN, e.gap);
    end
  endtask

  // Monitor: turns tone bursts and status pulses into events for the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      in_tone = 0;
      low_run = 0;
    end else begin
      if (tone_en) begin
        if (in_tone == 0) begin
          in_tone     = 1;
          tone_len    = 0;
          tone_val    = int'(tone);
          tone_glitch = 0;
          gap_seen    = low_run;
        end
        tone_len++;
        if (int'(tone) != tone_val) tone_glitch = 1;
      end else begin
        if (in_tone != 0) begin
          in_tone = 0;
          score_event(EV_TONE, (tone_glitch != 0) ? 99 : tone_val, tone_len, gap_seen);
          low_run = 0;
        end
        low_run++;
      end
      if (miss)      score_event(EV_MISS, 0, 0, -1);
      if (round_win) score_event(EV_WIN, 0, 0, -1);
    end
  end

  task automatic push_ev(input int kind, input int note, input int gap);
    ev_t e;
    e.kind = kind;
    e.note = note;
    e.gap  = gap;
    sb_q.push_back(e);
  endtask

  // Queue the playback of the current round; first_after_start has no defined gap.
  task automatic push_round(input bit first_after_start);
    for (int i = 0; i < m_len; i++)
      push_ev(EV_TONE, m_notes[i], (first_after_start && i == 0) ? -1 : GAP_LEN);
  endtask

  task automatic apply_stimulus_load(input int n0, input int n1, input int n2, input int n3,
                                     input bit with_start);
    @(negedge clk);
    m_notes[0] = n0; m_notes[1] = n1; m_notes[2] = n2; m_notes[3] = n3;
    for (int i = 0; i < MAX_LEN; i++) seq_data[i*NOTE_W +: NOTE_W] = NOTE_W'(m_notes[i]);
    seq_wr = 1'b1;
    start  = with_start;
    @(negedge clk);
    seq_wr = 1'b0;
    start  = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (key_ready) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400; i++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
    end
    check_output("sb_drained", sb_q.size(), 0);
    sb_q.delete();
  endtask

  // One full game; policy 0 = always right, 1 = always wrong, 2 = mostly right.
  task automatic play_game(input bit rev, input int policy);
    int k, exp_note, key;
    bit correct, done, ok;
    m_len = START_LEN; m_lives = LIVES; m_score = 0; m_rev = rev;
    m_over = 0; m_won = 0;
    @(negedge clk);
    reverse_mode = rev;
    start = 1'b1;
    push_round(1'b1);
    @(negedge clk);
    start = 1'b0;
    k = 0;
    done = 0;
    while (!done) begin
      wait_ready(ok);
      check_output("key_ready_seen", int'(ok), 1);
      if (!ok) begin
        sb_q.delete();
        return;
      end
      check_output("wait_state", int'(state_out), 3);
      check_output("score", int'(score), m_score);
      check_output("lives_left", int'(lives_left), m_lives);
      check_output("cur_len", int'(cur_len), m_len);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      exp_note = m_rev ? m_notes[m_len-1-k] : m_notes[k];
      correct  = (policy == 0) || (policy == 2 && $urandom_range(0, 99) < 70);
      key      = correct ? exp_note : (exp_note + int'($urandom_range(1, 7))) % 8;
      key_valid = 1'b1;
      key_note  = NOTE_W'(key);
      push_ev(EV_TONE, key, -1);
      @(negedge clk);
      key_valid = 1'b0;
      if (correct) begin
        m_score++;
        k++;
        if (k == m_len) begin
          push_ev(EV_WIN, 0, -1);
          if (m_len == MAX_LEN) begin
            m_won = 1;
            done  = 1;
          end else begin
            m_len++;
            k = 0;
            push_round(1'b0);
          end
        end
      end else begin
        push_ev(EV_MISS, 0, -1);
        m_lives--;
        k = 0;
        if (m_lives == 0) begin
          m_over = 1;
          done   = 1;
        end else begin
          push_round(1'b0);
        end
      end
    end
    wait_drain();
    repeat (2) @(negedge clk);
    check_output("end_state", int'(state_out), 5);
    check_output("end_key_ready", int'(key_ready), 0);
    check_output("end_tone_en", int'(tone_en), 0);
    check_output("end_game_over", int'(game_over), int'(m_over));
    check_output("end_game_won", int'(game_won), int'(m_won));
    check_output("end_score", int'(score), m_score);
    check_output("end_lives", int'(lives_left), m_lives);
    check_output("end_cur_len", int'(cur_len), m_len);
    // Keys after the game has ended must be ignored; the monitor flags any echo.
    repeat (2) begin
      @(negedge clk);
      key_valid = 1'b1;
      key_note  = NOTE_W'($urandom_range(0, 7));
      @(negedge clk);
      key_valid = 1'b0;
    end
    repeat (12) @(negedge clk);
    check_output("done_hold_state", int'(state_out), 5);
    check_output("done_hold_score", int'(score), m_score);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    #3;
    check_output("rst_state", int'(state_out), 0);
    check_output("rst_tone_en", int'(tone_en), 0);
    check_output("rst_tone", int'(tone), 0);
    check_output("rst_key_ready", int'(key_ready), 0);
    check_output("rst_cur_len", int'(cur_len), 0);
    check_output("rst_lives", int'(lives_left), 0);
    check_output("rst_score", int'(score), 0);
    check_output("rst_flags", int'({miss, round_win, game_over, game_won}), 0);
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b0;

    $display("[TB] directed: forward win, then restart without reload");
    apply_stimulus_load(1, 2, 3, 4, 1'b0);
    play_game(1'b0, 0);
    play_game(1'b1, 0);
    $display("[TB] directed: wrong keys until game over");
    play_game(1'b0, 1);

    $display("[TB] randomized games");
    for (int g = 0; g < 6; g++) begin
      apply_stimulus_load($urandom_range(0, 7), $urandom_range(0, 7),
                          $urandom_range(0, 7), $urandom_range(0, 7), 1'b0);
      play_game(1'($urandom_range(0, 1)), 2);
    end

    $display("[TB] reset during playback and start priority");
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tone_en) break;
      @(negedge clk);
    end
    check_output("playing_before_reset", int'(tone_en), 1);
    #1 reset = 1'b1;
    #1;
    check_output("midplay_rst_tone_en", int'(tone_en), 0);
    check_output("midplay_rst_state", int'(state_out), 0);
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check_output("start_unloaded_state", int'(state_out), 0);
    apply_stimulus_load($urandom_range(0, 7), $urandom_range(0, 7),
                        $urandom_range(0, 7), $urandom_range(0, 7), 1'b1);
    repeat (20) @(negedge clk);
    check_output("wr_start_same_cycle_state", int'(state_out), 0);
    check_output("wr_start_same_cycle_tone_en", int'(tone_en), 0);
    play_game(1'($urandom_range(0, 1)), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
